// File: rtl/fifo_burst_scheduler.sv
// rtl/fifo_burst_scheduler.sv - round-robin SDRAM write-burst scheduler draining two pixel FIFOs
module fifo_burst_scheduler #(
  parameter int unsigned        PTR_WD      = 10,
  parameter int unsigned        DATA_WD     = 16,
  parameter int unsigned        ADDR_WD     = 22,
  parameter int unsigned        BURST_LEN   = 256,
  parameter logic [ADDR_WD-1:0] BASE_A      = 22'h000000,
  parameter logic [ADDR_WD-1:0] BASE_B      = 22'h200000,
  parameter int unsigned        FRAME_WORDS = 307200
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [PTR_WD-1:0]  a_cnt_i,
  input  logic               a_full_i,
  input  logic               a_empty_i,
  output logic               a_rd_en_o,
  input  logic [DATA_WD-1:0] a_data_i,
  input  logic [PTR_WD-1:0]  b_cnt_i,
  input  logic               b_full_i,
  input  logic               b_empty_i,
  output logic               b_rd_en_o,
  input  logic [DATA_WD-1:0] b_data_i,
  input  logic               frame_start_i,
  input  logic               flush_i,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic [ADDR_WD-1:0] cmd_addr_o,
  output logic [PTR_WD:0]    cmd_len_o,
  output logic               cmd_ch_o,
  output logic               wr_valid_o,
  input  logic               wr_ready_i,
  output logic [DATA_WD-1:0] wr_data_o,
  output logic               busy_o
);

  localparam int unsigned   LW    = PTR_WD + 1;
  localparam int unsigned   DEPTH = 1 << PTR_WD;
  localparam logic [LW-1:0] BURST = LW'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_XFER, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LW-1:0]      lvl_a, lvl_b, grant_lvl, grant_len;
  logic               elig_a, elig_b, grant_any, grant_ch;
  logic               flush_a_q, flush_b_q, rr_q, fs_pend_q;
  logic [ADDR_WD-1:0] addr_a_q, addr_b_q, cmd_addr_q;
  logic [LW-1:0]      len_q, req_cnt_q, xfer_cnt_q;
  logic               ch_q, inflight_q, in_xfer, rd_go, push, pop, last_word;
  logic [DATA_WD-1:0] skid_mem_q [2];
  logic               skid_wr_q, skid_rd_q;
  logic [1:0]         skid_cnt_q, occ;
  logic [DATA_WD-1:0] data_sel;

  // Advance a channel address by len words, folding back into the frame window.
  function automatic logic [ADDR_WD-1:0] next_addr(input logic [ADDR_WD-1:0] addr,
                                                   input logic [ADDR_WD-1:0] base,
                                                   input logic [LW-1:0]      len);
    logic [31:0] off;
    off = 32'(addr) - 32'(base) + 32'(len);
    if (off >= FRAME_WORDS) off = off - FRAME_WORDS;
    return ADDR_WD'(32'(base) + off);
  endfunction

  // Effective fill level and eligibility; full with count 0 means a completely full FIFO.
  assign lvl_a  = a_full_i ? LW'(DEPTH) : {1'b0, a_cnt_i};
  assign lvl_b  = b_full_i ? LW'(DEPTH) : {1'b0, b_cnt_i};
  assign elig_a = (lvl_a >= BURST) || (flush_a_q && !a_empty_i);
  assign elig_b = (lvl_b >= BURST) || (flush_b_q && !b_empty_i);

  // Round-robin choice: rr_q names the preferred channel when both are eligible.
  assign grant_any = elig_a | elig_b;
  assign grant_ch  = (elig_a && elig_b) ? rr_q : elig_b;
  assign grant_lvl = grant_ch ? lvl_b : lvl_a;
  assign grant_len = (grant_lvl < BURST) ? grant_lvl : BURST;

  // Read pacing: never more than two words between FIFO and skid buffer, never past len.
  assign occ       = skid_cnt_q + {1'b0, inflight_q};
  assign rd_go     = in_xfer && (req_cnt_q < len_q) && (occ < 2'd2);
  assign a_rd_en_o = rd_go & ~ch_q;
  assign b_rd_en_o = rd_go & ch_q;

  assign data_sel   = ch_q ? b_data_i : a_data_i;
  assign push       = inflight_q;
  assign wr_valid_o = in_xfer && (skid_cnt_q != 2'd0);
  assign wr_data_o  = skid_mem_q[skid_rd_q];
  assign pop        = wr_valid_o & wr_ready_i;
  assign last_word  = pop && (xfer_cnt_q == len_q - LW'(1));

  assign cmd_addr_o = cmd_addr_q;
  assign cmd_len_o  = len_q;
  assign cmd_ch_o   = ch_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_any) state_d = S_CMD;
      S_CMD:   if (cmd_ready_i) state_d = S_XFER;
      S_XFER:  if (last_word) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    cmd_valid_o = 1'b0;
    busy_o      = 1'b1;
    in_xfer     = 1'b0;
    case (state_q)
      S_IDLE:  busy_o = 1'b0;
      S_CMD:   cmd_valid_o = 1'b1;
      S_XFER:  in_xfer = 1'b1;
      default: ;
    endcase
  end

  // Arbitration bookkeeping: flush flags, frame restarts, command latch, address advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_a_q  <= 1'b0;
      flush_b_q  <= 1'b0;
      rr_q       <= 1'b0;
      fs_pend_q  <= 1'b0;
      addr_a_q   <= BASE_A;
      addr_b_q   <= BASE_B;
      cmd_addr_q <= '0;
      len_q      <= '0;
      ch_q       <= 1'b0;
    end else begin
      if (flush_i) begin
        flush_a_q <= 1'b1;
        flush_b_q <= 1'b1;
      end else if (state_q == S_IDLE) begin
        if (a_empty_i) flush_a_q <= 1'b0;
        if (b_empty_i) flush_b_q <= 1'b0;
        if (grant_any && (grant_lvl < BURST)) begin
          if (grant_ch) flush_b_q <= 1'b0;
          else          flush_a_q <= 1'b0;
        end
      end
      case (state_q)
        S_IDLE: begin
          fs_pend_q <= 1'b0;
          if (frame_start_i) begin
            addr_a_q <= BASE_A;
            addr_b_q <= BASE_B;
          end
          if (grant_any) begin
            ch_q  <= grant_ch;
            len_q <= grant_len;
            if (frame_start_i) cmd_addr_q <= grant_ch ? BASE_B : BASE_A;
            else               cmd_addr_q <= grant_ch ? addr_b_q : addr_a_q;
          end
        end
        S_DONE: begin
          fs_pend_q <= 1'b0;
          rr_q      <= ~ch_q;
          if (fs_pend_q || frame_start_i) begin
            addr_a_q <= BASE_A;
            addr_b_q <= BASE_B;
          end else if (ch_q) begin
            addr_b_q <= next_addr(addr_b_q, BASE_B, len_q);
          end else begin
            addr_a_q <= next_addr(addr_a_q, BASE_A, len_q);
          end
        end
        default: if (frame_start_i) fs_pend_q <= 1'b1;
      endcase
    end
  end

  // Burst datapath: read counter, one-cycle read latency tracking and 2-entry skid FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_cnt_q     <= '0;
      xfer_cnt_q    <= '0;
      inflight_q    <= 1'b0;
      skid_wr_q     <= 1'b0;
      skid_rd_q     <= 1'b0;
      skid_cnt_q    <= 2'd0;
      skid_mem_q[0] <= '0;
      skid_mem_q[1] <= '0;
    end else if (!in_xfer) begin
      req_cnt_q  <= '0;
      xfer_cnt_q <= '0;
      inflight_q <= 1'b0;
      skid_wr_q  <= 1'b0;
      skid_rd_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
    end else begin
      inflight_q <= rd_go;
      if (rd_go) req_cnt_q <= req_cnt_q + LW'(1);
      if (push) begin
        skid_mem_q[skid_wr_q] <= data_sel;
        skid_wr_q             <= ~skid_wr_q;
      end
      if (pop) begin
        skid_rd_q  <= ~skid_rd_q;
        xfer_cnt_q <= xfer_cnt_q + LW'(1);
      end
      case ({push, pop})
        2'b10:   skid_cnt_q <= skid_cnt_q + 2'd1;
        2'b01:   skid_cnt_q <= skid_cnt_q - 2'd1;
        default: skid_cnt_q <= skid_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// tb/tb_fifo_burst_scheduler.sv - scoreboard bench for fifo_burst_scheduler
module tb_fifo_burst_scheduler;

  localparam int BL = 256;
  localparam int FW = 300;
  localparam int BA = 32'h000000;
  localparam int BB = 32'h200000;

  typedef struct {int ch; int addr; int len;} cmd_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  a_cnt, b_cnt;
  logic        a_full, b_full, a_empty, b_empty, a_rd_en, b_rd_en;
  logic [15:0] a_data, b_data, wr_data;
  logic        frame_start, flush;
  logic        cmd_valid, cmd_ready, cmd_ch;
  logic [21:0] cmd_addr;
  logic [10:0] cmd_len;
  logic        wr_valid, wr_ready, busy;

  fifo_burst_scheduler #(.FRAME_WORDS(FW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_cnt_i(a_cnt), .a_full_i(a_full), .a_empty_i(a_empty), .a_rd_en_o(a_rd_en), .a_data_i(a_data),
    .b_cnt_i(b_cnt), .b_full_i(b_full), .b_empty_i(b_empty), .b_rd_en_o(b_rd_en), .b_data_i(b_data),
    .frame_start_i(frame_start), .flush_i(flush),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_addr_o(cmd_addr),
    .cmd_len_o(cmd_len), .cmd_ch_o(cmd_ch),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_data_o(wr_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] qa[$], qb[$];
  logic [15:0] exp_a[$], exp_b[$];
  cmd_t        exp_cmd[$];
  int          m_addr[2];
  int          m_left[2];
  bit          m_flag[2];
  int          m_last;
  bit          cmd_mode, wr_mode;

  bit          active;
  int          cur_ch, cur_len, words, rd_cnt;
  cmd_t        mon_e;
  logic [15:0] mon_d;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic upd();
    a_cnt   = 10'(qa.size());
    a_full  = (qa.size() == 1024);
    a_empty = (qa.size() == 0);
    b_cnt   = 10'(qb.size());
    b_full  = (qb.size() == 1024);
    b_empty = (qb.size() == 0);
  endtask

  task automatic tick();
    bit ra, rb;
    @(negedge clk);
    ra = a_rd_en;
    rb = b_rd_en;
    @(posedge clk);
    #1;
    if (ra && qa.size() > 0) a_data = qa.pop_front();
    if (rb && qb.size() > 0) b_data = qb.pop_front();
    upd();
    cmd_ready = cmd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    wr_ready  = wr_mode  ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic fill(input int ch, input int n);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      if (ch == 0) begin qa.push_back(w); exp_a.push_back(w); end
      else         begin qb.push_back(w); exp_b.push_back(w); end
    end
    upd();
  endtask

  // Burst-level reference: repeatedly pick an eligible channel, carve a burst, advance addresses.
  task automatic predict();
    int lv[2];
    bit e[2];
    int ch, len, base, off;
    lv[0] = qa.size();
    lv[1] = qb.size();
    for (int it = 0; it < 16; it++) begin
      for (int c = 0; c < 2; c++) begin
        if (lv[c] == 0) m_flag[c] = 0;
        e[c] = (lv[c] >= BL) || (m_flag[c] && lv[c] > 0);
      end
      if (!e[0] && !e[1]) break;
      ch  = (e[0] && e[1]) ? 1 - m_last : (e[0] ? 0 : 1);
      len = (lv[ch] < BL) ? lv[ch] : BL;
      if (lv[ch] < BL) m_flag[ch] = 0;
      exp_cmd.push_back('{ch, m_addr[ch], len});
      base = ch ? BB : BA;
      off  = m_addr[ch] - base + len;
      if (off >= FW) off -= FW;
      m_addr[ch] = base + off;
      lv[ch] -= len;
      m_last = ch;
    end
    m_left[0] = lv[0];
    m_left[1] = lv[1];
  endtask

  task automatic model_reset();
    m_addr[0] = BA;
    m_addr[1] = BB;
    m_flag[0] = 0;
    m_flag[1] = 0;
    m_last    = 1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_cmd.size() != 0 || active || busy) && n < 30000) begin
      tick();
      n++;
    end
    chk(n < 30000, {tag, "_timeout"}, n, 30000);
    repeat (6) tick();
    chk(!busy, {tag, "_idle"}, busy, 0);
    chk(qa.size() == m_left[0], {tag, "_left_a"}, qa.size(), m_left[0]);
    chk(qb.size() == m_left[1], {tag, "_left_b"}, qb.size(), m_left[1]);
  endtask

  task automatic check_zero(input string tag);
    chk(cmd_valid == 0, {tag, "_cmd_valid"}, cmd_valid, 0);
    chk(wr_valid == 0, {tag, "_wr_valid"}, wr_valid, 0);
    chk(a_rd_en == 0, {tag, "_a_rd_en"}, a_rd_en, 0);
    chk(b_rd_en == 0, {tag, "_b_rd_en"}, b_rd_en, 0);
    chk(busy == 0, {tag, "_busy"}, busy, 0);
    chk(cmd_addr == 0, {tag, "_cmd_addr"}, cmd_addr, 0);
    chk(cmd_len == 0, {tag, "_cmd_len"}, cmd_len, 0);
    chk(cmd_ch == 0, {tag, "_cmd_ch"}, cmd_ch, 0);
    chk(wr_data == 0, {tag, "_wr_data"}, wr_data, 0);
  endtask

  task automatic pulse_frame_start_idle();
    frame_start = 1'b1;
    m_addr[0] = BA;
    m_addr[1] = BB;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_flush(input string tag);
    flush = 1'b1;
    m_flag[0] = 1;
    m_flag[1] = 1;
    predict();
    tick();
    flush = 1'b0;
    wait_idle(tag);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a command, a read or a data word.
  always @(negedge clk) begin
    if (!rst_n) begin
      active  = 0;
      words   = 0;
      rd_cnt  = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          chk(0, "unexpected_cmd", cmd_addr, 0);
        end else begin
          mon_e = exp_cmd.pop_front();
          chk(cmd_ch == 1'(mon_e.ch), "cmd_ch", cmd_ch, mon_e.ch);
          chk(cmd_addr == 22'(mon_e.addr), "cmd_addr", cmd_addr, mon_e.addr);
          chk(cmd_len == 11'(mon_e.len), "cmd_len", cmd_len, mon_e.len);
        end
        active  = 1;
        cur_ch  = int'(cmd_ch);
        cur_len = int'(cmd_len);
        words   = 0;
        rd_cnt  = 0;
      end
      if (a_rd_en) begin
        rd_cnt++;
        chk(active && cur_ch == 0 && qa.size() > 0, "a_rd_legal", qa.size(), 1);
        chk(rd_cnt <= cur_len && rd_cnt - words <= 2, "a_rd_bound", rd_cnt, cur_len);
      end
      if (b_rd_en) begin
        rd_cnt++;
        chk(active && cur_ch == 1 && qb.size() > 0, "b_rd_legal", qb.size(), 1);
        chk(rd_cnt <= cur_len && rd_cnt - words <= 2, "b_rd_bound", rd_cnt, cur_len);
      end
      if (wr_valid && wr_ready) begin
        if (!active) begin
          chk(0, "unexpected_wr", wr_data, 0);
        end else if ((cur_ch == 0 ? exp_a.size() : exp_b.size()) == 0) begin
          chk(0, "wr_no_expected", wr_data, 0);
        end else begin
          mon_d = (cur_ch == 0) ? exp_a.pop_front() : exp_b.pop_front();
          chk(wr_data == mon_d, "wr_data", wr_data, mon_d);
          words++;
          if (words == cur_len) begin
            chk(rd_cnt == cur_len, "rd_total", rd_cnt, cur_len);
            active = 0;
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b1;
    frame_start = 1'b0;
    flush = 1'b0;
    cmd_ready = 1'b0;
    wr_ready = 1'b0;
    a_data = '0;
    b_data = '0;
    cmd_mode = 1'b1;
    wr_mode = 1'b0;
    upd();
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk(!busy, "post_reset_idle", busy, 0);

    // Round-robin with both FIFOs completely full.
    fill(0, 1024);
    fill(1, 1024);
    chk(a_full && a_cnt == 0, "full_encoding", a_cnt, 0);
    predict();
    wait_idle("rr");

    // Single channel burst from a clean frame base, then a flush of the 37-word remainder.
    pulse_frame_start_idle();
    fill(0, 293);
    predict();
    wait_idle("a_only");
    do_flush("flush37");

    // Partial level without flush must stay idle.
    fill(0, 100);
    predict();
    wait_idle("no_flush");

    // Backpressure on channel B.
    wr_mode = 1'b1;
    fill(1, 256);
    predict();
    wait_idle("backpressure");
    wr_mode = 1'b0;

    // Address wrap inside the frame window, then frame_start during a burst.
    pulse_frame_start_idle();
    fill(0, 412);
    predict();
    wait_idle("wrap");
    fill(0, 256);
    predict();
    n = 0;
    while (!active && n < 200) begin tick(); n++; end
    chk(n < 200, "fs_wait_active", n, 200);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_idle("fs_mid");
    m_addr[0] = BA;
    m_addr[1] = BB;
    fill(0, 256);
    fill(1, 256);
    predict();
    wait_idle("fs_after");

    // Randomised phases.
    for (int p = 0; p < 10; p++) begin
      wr_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) pulse_frame_start_idle();
      fill(0, $urandom_range(0, 500));
      fill(1, $urandom_range(0, 500));
      predict();
      wait_idle("rand");
      if ($urandom_range(0, 1) == 1) do_flush("rand_flush");
    end
    wr_mode = 1'b0;
    if (qa.size() > 0 || qb.size() > 0) do_flush("drain");

    // Reset in the middle of a transfer.
    fill(0, 300);
    predict();
    n = 0;
    while (words < 100 && n < 2000) begin tick(); n++; end
    chk(n < 2000, "rst_wait_words", words, 100);
    rst_n = 1'b0;
    #1 check_zero("mid_reset");
    qa.delete();
    qb.delete();
    exp_a.delete();
    exp_b.delete();
    exp_cmd.delete();
    model_reset();
    upd();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk(!busy, "after_reset_idle", busy, 0);
    fill(0, 256);
    predict();
    wait_idle("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_scheduler.md
Name: fifo_burst_scheduler

Overview:
Shares one SDRAM write-burst port between two pixel async FIFOs (channel A and channel B, read side). It arbitrates round-robin between the channels and issues a burst command (address, length). It then drains exactly that many words from the granted FIFO onto the write-data handshake. It runs entirely in the FIFO read / SDRAM clock domain and sits between the FIFO read ports and the SDRAM controller.

Parameters:
PTR_WD, 10, FIFO pointer width; FIFO depth is 2**PTR_WD
DATA_WD, 16, pixel word width
ADDR_WD, 22, SDRAM word address width
BURST_LEN, 256, full burst length in words; must be ≤ 2**PTR_WD and ≥ 1
BASE_A, 22'h000000, channel A frame base address
BASE_B, 22'h200000, channel B frame base address
FRAME_WORDS, 307200, words per frame per channel; the address wraps to base after this many words

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
a_cnt_i  in  PTR_WD  channel A FIFO read-side data count (mod depth)
a_full_i  in  1  channel A FIFO full (disambiguates count 0)
a_empty_i  in  1  channel A FIFO empty
a_rd_en_o  out  1  channel A FIFO read strobe
a_data_i  in  DATA_WD  channel A read data, valid 1 cycle after rd_en
b_cnt_i, b_full_i, b_empty_i, b_rd_en_o, b_data_i  same as channel A, for channel B
frame_start_i  in  1  pulse: reset both channel addresses to base
flush_i  in  1  pulse: end of frame, allow partial bursts
cmd_valid_o  out  1  burst command valid
cmd_ready_i  in  1  burst command accepted
cmd_addr_o  out  ADDR_WD  burst start address
cmd_len_o  out  PTR_WD+1  burst length in words, 1..BURST_LEN
cmd_ch_o  out  1  0 = A, 1 = B
wr_valid_o  out  1  write data valid
wr_ready_i  in  1  write data accepted
wr_data_o  out  DATA_WD  write data
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset clock and polarity: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: all outputs 0; channel addresses = BASE_A / BASE_B; round-robin pointer = A; flush-pending flags = 0; state = IDLE.
- Effective level: lvl = full ? 2**PTR_WD : cnt, computed as a PTR_WD+1-bit value.
- Channel eligibility: a channel is eligible when lvl ≥ BURST_LEN, or when its flush-pending flag is set and empty = 0.
- Flush-pending flags: flush_i sets both flags. A flag clears when its channel is granted with lvl < BURST_LEN, or when its channel is observed empty in IDLE.
- IDLE state:
  - If both channels are eligible, grant the channel opposite the last-granted one.
  - If one is eligible, grant it.
  - Latch len = min(lvl, BURST_LEN), the channel, and the address, then go to CMD.
- CMD state: hold cmd_valid_o = 1 with addr, len and ch stable until cmd_ready_i is sampled high, then go to XFER. The command handshake completes on the cycle where valid and ready are both high.
- XFER state:
  - Read-strobe counter: rd_en is asserted for the granted channel while words-requested < len and skid occupancy + in-flight < 2.
  - Skid buffer: the FIFO read latency is 1 cycle, so the read data is captured into a 2-entry skid FIFO.
  - Output: wr_valid_o = skid non-empty; wr_data_o = skid head. A word transfers when wr_valid_o and wr_ready_i are both high.
  - Completion: when the transferred count equals len, go to DONE. No rd_en is ever issued beyond len words, and never to the non-granted channel.
- DONE state (1 cycle):
  - Address update: addr_ch += len. If the result is ≥ base + FRAME_WORDS, it wraps to base + (result − base − FRAME_WORDS).
  - Update the round-robin pointer, then go to IDLE.
- Burst-to-burst gap: minimum latency from eligibility to cmd_valid_o is 1 cycle. There are at least 2 idle cycles between bursts.
- frame_start_i:
  - In IDLE it resets the addresses immediately.
  - Otherwise it is held pending and applied in DONE, replacing the increment for both channels.
- Simultaneous flush_i and frame_start_i: both take effect.
- wr_ready_i low indefinitely: the block stalls with no data loss and no extra reads.
- cmd_len_o is never 0. The FIFO is never read when empty (len ≤ lvl at grant, and the write side only adds data).
- Reset mid-burst: immediate return to reset values; partially drained data is discarded.

Test Plan:
1. Burst from A only: A lvl = 300, B empty, wr_ready = 1 → cmd (addr 0, len 256, ch 0); exactly 256 a_rd_en pulses; 256 words out in FIFO order; next A address = 256.
2. Round-robin: both channels full (full = 1, cnt = 0) → grants A, B, A, B; lengths 256 each; the B address sequence is 0x200000, 0x200100.
3. Backpressure: wr_ready toggles 1-0-0-1 randomly during a burst → the data sequence is intact; no more than 2 words are buffered; the total rd_en count equals len.
4. Flush: A lvl = 37, flush_i pulse → cmd len 37; afterwards A is not eligible with lvl < 256 and no flush.
5. Address wrap: FRAME_WORDS = 300, two 256-word bursts on A → second address 256, then the next address wraps to 212. frame_start_i mid-burst → the address after DONE is BASE.
6. Reset mid-XFER: assert rst_ni low after 100 words → all outputs 0 asynchronously; after release, the address is BASE_A and the state is IDLE.
